// File: rtl/tapped_delay_pipe_if.sv
// tapped_delay_pipe_if: sample input and registered tap output of the delay pipe
interface tapped_delay_pipe_if #(parameter int WIDTH = 8);
    logic             in_valid;
    logic [WIDTH-1:0] in_data;
    logic             out_valid;
    logic [WIDTH-1:0] out_data;
    modport master (output in_valid, in_data, input out_valid, out_data);
    modport slave (input in_valid, in_data, output out_valid, out_data);
endinterface

// File: rtl/tapped_delay_pipe.sv
// tapped_delay_pipe: registered tapped delay line with stall, flush, selectable tap and occupancy
module tapped_delay_pipe #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    parameter int SEL_W = $clog2(DEPTH),
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic                   clk,
    input  logic                   rst,
    tapped_delay_pipe_if.slave     bus,
    input  logic                   en,
    input  logic                   flush,
    input  logic [SEL_W-1:0]       tap_sel,
    output logic [DEPTH*WIDTH-1:0] taps,
    output logic [DEPTH-1:0]       taps_valid,
    output logic [CNT_W-1:0]       occupancy,
    output logic                   drop
);
    localparam int NSEL = 1 << SEL_W;
    // selects beyond the last stage read a constant zero slot
    logic [NSEL-1:0]  sel_v;
    logic [WIDTH-1:0] sel_d [NSEL];
    for (genvar i = 0; i < NSEL; i++) begin : g_sel
        if (i < DEPTH) begin : g_in
            assign sel_v[i] = taps_valid[i];
            assign sel_d[i] = taps[i*WIDTH +: WIDTH];
        end else begin : g_pad
            assign sel_v[i] = 1'b0;
            assign sel_d[i] = '0;
        end
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            taps          <= '0;
            taps_valid    <= '0;
            occupancy     <= '0;
            drop          <= 1'b0;
            bus.out_valid <= 1'b0;
            bus.out_data  <= '0;
        end else begin
            drop          <= en & ~flush & taps_valid[DEPTH-1];
            bus.out_valid <= ~flush & sel_v[tap_sel];
            bus.out_data  <= sel_d[tap_sel];
            if (flush) begin
                taps_valid <= '0;
                occupancy  <= '0;
            end else if (en) begin
                taps_valid <= {taps_valid[DEPTH-2:0], bus.in_valid};
                taps       <= {taps[(DEPTH-1)*WIDTH-1:0], bus.in_data};
                occupancy  <= occupancy + CNT_W'(bus.in_valid) - CNT_W'(taps_valid[DEPTH-1]);
            end
        end
    end
endmodule

// File: tb/tb_tapped_delay_pipe.sv
// tb_tapped_delay_pipe: directed and random checks of DEPTH=4 and DEPTH=5 pipes against a stage-array model
module tb_tapped_delay_pipe;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic       iv, en, flush;
    logic [7:0] idata;
    logic [1:0] ts4;
    logic [2:0] ts5;
    logic [31:0] taps4;
    logic [39:0] taps5;
    logic [3:0]  tv4;
    logic [4:0]  tv5;
    logic [2:0]  occ4, occ5;
    logic        drop4, drop5;

    tapped_delay_pipe_if #(.WIDTH(8)) b4 ();
    tapped_delay_pipe_if #(.WIDTH(8)) b5 ();
    assign b4.in_valid = iv;
    assign b4.in_data  = idata;
    assign b5.in_valid = iv;
    assign b5.in_data  = idata;

    tapped_delay_pipe #(.WIDTH(8), .DEPTH(4)) u4 (
        .clk(clk), .rst(rst), .bus(b4), .en(en), .flush(flush), .tap_sel(ts4),
        .taps(taps4), .taps_valid(tv4), .occupancy(occ4), .drop(drop4));
    tapped_delay_pipe #(.WIDTH(8), .DEPTH(5)) u5 (
        .clk(clk), .rst(rst), .bus(b5), .en(en), .flush(flush), .tap_sel(ts5),
        .taps(taps5), .taps_valid(tv5), .occupancy(occ5), .drop(drop5));

    int checks = 0;
    int errors = 0;
    int dep [2] = '{4, 5};
    logic       mv [2][8];
    logic [7:0] md [2][8];
    logic       ev [2];
    logic [7:0] ed [2];
    logic       edrop [2];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            ev[k] = 1'b0; ed[k] = 8'h0; edrop[k] = 1'b0;
            for (int i = 0; i < 8; i++) begin mv[k][i] = 1'b0; md[k][i] = 8'h0; end
        end
    endtask

    task automatic compare();
        logic [63:0] et, etv;
        int oc;
        for (int k = 0; k < 2; k++) begin
            et = '0; etv = '0; oc = 0;
            for (int i = 0; i < dep[k]; i++) begin
                et[i*8 +: 8] = md[k][i];
                etv[i] = mv[k][i];
                oc += int'(mv[k][i]);
            end
            if (k == 0) begin
                chk("u4.out_valid", b4.out_valid, ev[0]);
                chk("u4.out_data", b4.out_data, ed[0]);
                chk("u4.taps", taps4, et);
                chk("u4.taps_valid", tv4, etv);
                chk("u4.occupancy", occ4, oc);
                chk("u4.drop", drop4, edrop[0]);
            end else begin
                chk("u5.out_valid", b5.out_valid, ev[1]);
                chk("u5.out_data", b5.out_data, ed[1]);
                chk("u5.taps", taps5, et);
                chk("u5.taps_valid", tv5, etv);
                chk("u5.occupancy", occ5, oc);
                chk("u5.drop", drop5, edrop[1]);
            end
        end
    endtask

    // model advances on the edge using the inputs held across it, then checks 1ns later
    task automatic tick();
        int ts;
        @(posedge clk);
        if (rst) model_reset();
        else for (int k = 0; k < 2; k++) begin
            ts = (k == 0) ? int'(ts4) : int'(ts5);
            edrop[k] = en && !flush && mv[k][dep[k]-1];
            ev[k] = !flush && ts < dep[k] && mv[k][ts];
            ed[k] = (ts < dep[k]) ? md[k][ts] : 8'h0;
            if (flush) for (int i = 0; i < 8; i++) mv[k][i] = 1'b0;
            else if (en) begin
                for (int i = dep[k] - 1; i > 0; i--) begin
                    mv[k][i] = mv[k][i-1];
                    md[k][i] = md[k][i-1];
                end
                mv[k][0] = iv;
                md[k][0] = idata;
            end
        end
        #1;
        compare();
    endtask

    task automatic drive(input logic v, input logic [7:0] d, input logic e, input logic f);
        iv = v; idata = d; en = e; flush = f;
    endtask

    initial begin
        logic [7:0] q[$];
        int first1, first6, hit77;
        int occ_exp [6] = '{1, 2, 3, 4, 4, 4};
        int drop_exp [6] = '{0, 0, 0, 0, 1, 1};
        model_reset();
        drive(0, 8'h0, 1, 0);
        ts4 = 2'd0; ts5 = 3'd0;
        tick(); tick();
        rst = 1'b0;
        for (int c = 0; c < 3; c++) tick();
        chk("idle_out_valid", b4.out_valid, 0);

        // latency sweep over every tap
        for (int t = 0; t < 4; t++) begin
            ts4 = 2'(t);
            drive(1, 8'hA5, 1, 0);
            tick();
            drive(0, 8'h00, 1, 0);
            for (int e = 2; e <= 6; e++) begin
                tick();
                if (e == t + 2) begin
                    chk("lat_valid", b4.out_valid, 1);
                    chk("lat_data", b4.out_data, 8'hA5);
                end else chk("lat_quiet", b4.out_valid, 0);
                if (e == 5) chk("lat_drop5", drop4, 1);
            end
            chk("lat_occ0", occ4, 0);
        end

        // full chain
        for (int c = 0; c < 6; c++) begin
            drive(1, 8'(8'h10 + c), 1, 0);
            tick();
            chk("chain_occ", occ4, occ_exp[c]);
            chk("chain_drop", drop4, drop_exp[c]);
        end
        drive(0, 8'h0, 1, 0);
        for (int c = 0; c < 7; c++) tick();

        // stall mid-stream, tap 2
        ts4 = 2'd2; first1 = 0; first6 = 0;
        for (int c = 0, n = 1; c < 14; c++) begin
            if (c == 3 || c == 4) drive(1, 8'(n), 0, 0);
            else if (n <= 6) begin drive(1, 8'(n), 1, 0); n++; end
            else drive(0, 8'h0, 1, 0);
            tick();
            if (b4.out_valid && (q.size() == 0 || q[$] != b4.out_data)) begin
                q.push_back(b4.out_data);
                if (b4.out_data == 8'd1) first1 = c + 1;
                if (b4.out_data == 8'd6) first6 = c + 1;
            end
        end
        chk("stall_count", q.size(), 6);
        for (int i = 0; i < q.size(); i++) chk("stall_order", q[i], i + 1);
        chk("stall_first1_edge", first1, 4);
        chk("stall_first6_edge", first6, 11);

        // flush drops the concurrent input
        drive(0, 8'h0, 1, 0);
        for (int c = 0; c < 6; c++) tick();
        for (int c = 0; c < 3; c++) begin drive(1, 8'(8'h11 * (c + 1)), 1, 0); tick(); end
        chk("pre_flush_occ", occ4, 3);
        drive(1, 8'h77, 1, 1);
        tick();
        chk("flush_taps_valid", tv4, 0);
        chk("flush_occ", occ4, 0);
        chk("flush_out_valid", b4.out_valid, 0);
        hit77 = 0;
        drive(0, 8'h0, 1, 0);
        for (int c = 0; c < 6; c++) begin
            tick();
            if (b4.out_data == 8'h77 || b5.out_data == 8'h77) hit77++;
            for (int i = 0; i < 4; i++) if (taps4[i*8 +: 8] == 8'h77) hit77++;
        end
        chk("flush_no_77", hit77, 0);

        // out-of-range select on the 5-deep pipe
        ts5 = 3'd6;
        for (int c = 0; c < 8; c++) begin
            drive(1, 8'($urandom_range(0, 255)), 1, 0);
            tick();
            chk("oor_valid", b5.out_valid, 0);
            chk("oor_data", b5.out_data, 0);
        end

        // asynchronous reset mid-stream, checked between edges
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        chk("arst_u4_valid", b4.out_valid, 0);
        chk("arst_u4_data", b4.out_data, 0);
        chk("arst_u4_taps", taps4, 0);
        chk("arst_u4_tv", tv4, 0);
        chk("arst_u4_occ", occ4, 0);
        chk("arst_u4_drop", drop4, 0);
        chk("arst_u5_tv", tv5, 0);
        chk("arst_u5_occ", occ5, 0);
        tick();
        rst = 1'b0;
        drive(0, 8'h0, 1, 0);
        for (int c = 0; c < 4; c++) tick();

        // random traffic
        for (int c = 0; c < 300; c++) begin
            drive(1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)),
                  $urandom_range(0, 9) < 8, $urandom_range(0, 19) == 0);
            ts4 = 2'($urandom_range(0, 3));
            ts5 = 3'($urandom_range(0, 7));
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/tapped_delay_pipe.md
# tapped_delay_pipe

Parametrised, registered tapped delay line. A WIDTH-bit data word with a valid bit advances through DEPTH register stages. Any stage can be selected at run time onto a registered output, and the block tracks how many stages hold valid samples. It generalises the fixed single-bit registered-cell/buffer tap chains used in our timing examples into one block with configurable width, depth, stall and flush. It sits between a producer and a consumer that needs a selectable, cycle-exact delay, and it serves as a reference pipeline for internal timing-path reporting.

## Interface
- WIDTH, 8, data word width; minimum 1.
- DEPTH, 4, number of delay stages; minimum 2; need not be a power of two.
- SEL_W, $clog2(DEPTH), width of the tap select.
- CNT_W, $clog2(DEPTH+1), width of the occupancy count.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  qualifies in_data.
- in_data  in  WIDTH  input sample.
- en  in  1  advance strobe; 0 stalls the stage chain.
- flush  in  1  synchronous clear of all stage valid bits.
- tap_sel  in  SEL_W  stage routed to the output.
- out_valid  out  1  registered valid of the selected stage.
- out_data  out  WIDTH  registered data of the selected stage.
- taps  out  DEPTH*WIDTH  raw stage data; stage i occupies bits [i*WIDTH +: WIDTH].
- taps_valid  out  DEPTH  raw stage valid bits; bit i belongs to stage i.
- occupancy  out  CNT_W  number of stages with their valid bit set.
- drop  out  1  one-cycle pulse when a valid sample is shifted out of the last stage.

## Operation
- Stage state: v[i] and d[i] for i = 0..DEPTH-1.
- Advance (en=1, flush=0), on each rising edge:
  - v[0] <= in_valid; d[0] <= in_data.
  - v[i] <= v[i-1]; d[i] <= d[i-1] for i ≥ 1.
  - Data shifts even when its valid bit is 0.
- Stall (en=0, flush=0): v[] and d[] hold. in_data is ignored and is not buffered.
- Flush (flush=1, with or without en):
  - All v[] <= 0 and occupancy <= 0.
  - d[] holds.
  - The input presented in the same cycle is dropped. Flush has priority over advance.
- Output register (updates every cycle, independent of en):
  - out_valid <= v[tap_sel]; out_data <= d[tap_sel].
  - If tap_sel ≥ DEPTH: out_valid <= 0 and out_data <= 0.
  - During flush: out_valid <= 0 on that edge.
- Occupancy:
  - On advance: occupancy <= occupancy + in_valid − v[DEPTH-1].
  - On stall: holds.
  - occupancy must always equal popcount(v[]). It never exceeds DEPTH and never underflows.
- drop <= en & ~flush & v[DEPTH-1]; it is 0 on every other cycle.
- Reset (asynchronous, while rst=1): all v[], d[], out_valid, out_data, occupancy and drop are 0. Reset asserted mid-stream discards all in-flight samples immediately, without waiting for an edge.

## Timing
- Latency with en held at 1: a sample accepted at edge k is in stage t after edge k+t, and on out_data after edge k+t+1 for tap_sel = t. Total latency is tap_sel+2 edges from the cycle the sample is presented.
- taps and taps_valid are direct register outputs: one edge of latency to stage 0.
- A tap_sel change is visible on out_* after the next edge, including while stalled.
- Stall cycles add exactly one cycle of latency each. Samples are never duplicated or lost across a stall.
- In the cycle after flush: out_valid = 0 and occupancy = 0. A new sample presented then reaches stage 0 normally.
- Simultaneous in_valid=1 and v[DEPTH-1]=1 on advance: occupancy unchanged and drop = 1.
- No combinational path from any input to any output.

## Test plan
- Reset/idle: assert rst mid-stream with 3 valid samples loaded → all outputs 0 with no clock edge; after release with idle inputs, outputs stay 0.
- Latency sweep: DEPTH=4, en=1; send 0xA5 once, then idle; for each tap_sel 0..3 → out_data=0xA5 with out_valid=1 exactly at edge tap_sel+2, occupancy returns to 0, and drop=1 at edge 5.
- Stall: stream 0x01..0x06 with en low for 2 cycles mid-stream, tap_sel=2 → out sequence is 0x01..0x06 in order with no gaps or duplicates, and the output is delayed by 2 cycles.
- Full chain: 6 consecutive valid samples → occupancy goes 1, 2, 3, 4, then holds at 4 while drop=1 for 2 cycles.
- Flush: occupancy=3, then flush=1 together with in_valid=1 and in_data=0x77 → next cycle taps_valid=0, occupancy=0, out_valid=0, and 0x77 never appears on any output.
- Out-of-range select: DEPTH=5, tap_sel=6 → out_valid=0 and out_data=0 while taps still shift normally.
